imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the decode-stage immediate extender.
- Takes the full decode-stage instruction word and an immediate-format select, and builds an XLEN-wide immediate.
- Supports extra formats beyond the base set: CSR zimm, shift amount, and an illegal-format flag.
- The result is registered into the execute stage (1 or 2 register stages) with stall/flush control, a valid bit and a saturating illegal-format counter.
- Sits between the control decoder and the ID/EX boundary, and replaces the combinational extender plus its ImmExt pipeline register.

---
 rtl/imm_gen_pipe.sv | 83 ++++++++
 tb/tb_imm_gen_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate builder registered into execute, with stall/flush, valid and illegal-format counter
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          InstrD,
  input  logic [2:0]           ImmSrcD,
  input  logic                 ValidD,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic [XLEN-1:0]      ImmExtE,
  output logic                 ValidE,
  output logic                 ImmErrE,
  output logic [ERR_CNT_W-1:0] ImmErrCnt
);
  logic [XLEN-1:0]      w_imm;
  logic [XLEN-1:0]      w_d_imm;
  logic                 w_d_err;
  logic                 w_cnt_inc;
  logic [XLEN-1:0]      r_imm [PIPE_STAGES];
  logic                 r_vld [PIPE_STAGES];
  logic                 r_err [PIPE_STAGES];
  logic [ERR_CNT_W-1:0] r_cnt;

  // format decode; signed casts give sign extension from InstrD[31] to XLEN
  always_comb begin
    w_imm = '0;
    case (ImmSrcD)
      3'b000:  w_imm = XLEN'($signed(InstrD[31:20]));
      3'b001:  w_imm = XLEN'($signed({InstrD[31:25], InstrD[11:7]}));
      3'b010:  w_imm = XLEN'($signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}));
      3'b011:  w_imm = XLEN'($signed({InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0}));
      3'b100:  w_imm = XLEN'($signed({InstrD[31:12], 12'b0}));
      3'b101:  w_imm = XLEN'(InstrD[19:15]);
      3'b110:  w_imm = (XLEN == 64) ? XLEN'(InstrD[25:20]) : XLEN'(InstrD[24:20]);
      default: w_imm = '0;
    endcase
  end

  assign w_d_imm   = ValidD ? w_imm : '0;
  assign w_d_err   = ValidD & (ImmSrcD == 3'b111);
  assign w_cnt_inc = w_d_err & ~FlushE & ~StallE;

  // stage registers: flush beats stall, otherwise shift D values down the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_imm[i] <= '0;
        r_vld[i] <= 1'b0;
        r_err[i] <= 1'b0;
      end
    end else if (FlushE) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_imm[i] <= '0;
        r_vld[i] <= 1'b0;
        r_err[i] <= 1'b0;
      end
    end else if (!StallE) begin
      r_imm[0] <= w_d_imm;
      r_vld[0] <= ValidD;
      r_err[0] <= w_d_err;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_imm[i] <= r_imm[i-1];
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
      end
    end
  end

  // saturating illegal-format counter, survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_cnt_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign ImmExtE   = r_imm[PIPE_STAGES-1];
  assign ValidE    = r_vld[PIPE_STAGES-1];
  assign ImmErrE   = r_err[PIPE_STAGES-1];
  assign ImmErrCnt = r_cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: checks a 32-bit single-stage and a 64-bit two-stage instance against a behavioural model
module tb_imm_gen_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] InstrD = 0;
  logic [2:0]  ImmSrcD = 0;
  logic        ValidD = 0, StallE = 0, FlushE = 0;
  logic [31:0] imm_a;
  logic        vld_a, err_a;
  logic [7:0]  cnt_a;
  logic [63:0] imm_b;
  logic        vld_b, err_b;
  logic [1:0]  cnt_b;
  int n_cmp = 0, n_fail = 0;

  logic [31:0] ma_imm;
  logic        ma_v, ma_e;
  logic [7:0]  ma_cnt;
  logic [63:0] mb_imm [2];
  logic        mb_v [2], mb_e [2];
  logic [1:0]  mb_cnt;
  logic [109:0] obs, expv;

  imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(1), .ERR_CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ImmSrcD(ImmSrcD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .ImmExtE(imm_a), .ValidE(vld_a), .ImmErrE(err_a), .ImmErrCnt(cnt_a));

  imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(2), .ERR_CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ImmSrcD(ImmSrcD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .ImmExtE(imm_b), .ValidE(vld_b), .ImmErrE(err_b), .ImmErrCnt(cnt_b));

  always #5 clk = ~clk;

  assign obs  = {imm_a, vld_a, err_a, cnt_a, imm_b, vld_b, err_b, cnt_b};
  assign expv = {ma_imm, ma_v, ma_e, ma_cnt, mb_imm[1], mb_v[1], mb_e[1], mb_cnt};

  function automatic longint sx(input longint v, input int n);
    return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel, input bit x64);
    longint u = longint'(ins);
    case (sel)
      3'd0: return sx((u >> 20) & 'hfff, 12);
      3'd1: return sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      3'd2: return sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      3'd3: return sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      3'd4: return sx(u & 'hfffff000, 32);
      3'd5: return (u >> 15) & 31;
      3'd6: return (u >> 20) & (x64 ? 63 : 31);
      default: return 0;
    endcase
  endfunction

  task automatic model_clear(input bit cnt_too);
    ma_imm = 0; ma_v = 0; ma_e = 0;
    for (int i = 0; i < 2; i++) begin mb_imm[i] = 0; mb_v[i] = 0; mb_e[i] = 0; end
    if (cnt_too) begin ma_cnt = 0; mb_cnt = 0; end
  endtask

  task automatic tick(input logic [31:0] ins, input logic [2:0] sel, input logic v, input logic st, input logic fl);
    logic [63:0] ra, rb;
    InstrD = ins; ImmSrcD = sel; ValidD = v; StallE = st; FlushE = fl;
    @(posedge clk);
    ra = ref_imm(ins, sel, 0);
    rb = ref_imm(ins, sel, 1);
    if (fl) model_clear(0);
    else if (!st) begin
      mb_imm[1] = mb_imm[0]; mb_v[1] = mb_v[0]; mb_e[1] = mb_e[0];
      mb_imm[0] = v ? rb : 0; mb_v[0] = v; mb_e[0] = v && sel == 3'd7;
      ma_imm = v ? ra[31:0] : 0; ma_v = v; ma_e = v && sel == 3'd7;
    end
    if (v && sel == 3'd7 && !fl && !st) begin
      if (ma_cnt != 8'd255) ma_cnt = ma_cnt + 1;
      if (mb_cnt != 2'd3) mb_cnt = mb_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 0;
    model_clear(1);
    #1 rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (obs !== 110'd0) begin
      n_fail++; $display("FAIL reset: got %h required 0", obs);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_formats();
    logic [31:0] ia [4] = '{32'hFFF00093, 32'hFE20AE23, 32'h0010006F, 32'h000FD073};
    logic [2:0]  sa [4] = '{3'd0, 3'd1, 3'd3, 3'd5};
    logic [31:0] ea [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h0000001F};
    logic [31:0] ib [2] = '{32'h800000B7, 32'h03F01013};
    logic [2:0]  sb [2] = '{3'd4, 3'd6};
    logic [63:0] eb [2] = '{64'hFFFFFFFF80000000, 64'h3F};
    for (int i = 0; i < 4; i++) begin
      tick(ia[i], sa[i], 1, 0, 0);
      n_cmp++;
      if (imm_a !== ea[i] || vld_a !== 1'b1) begin
        n_fail++; $display("FAIL fmt32_%0d: got %h/%b required %h/1", i, imm_a, vld_a, ea[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(ib[i], sb[i], 1, 0, 0);
      tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (imm_b !== eb[i] || vld_b !== 1'b1) begin
        n_fail++; $display("FAIL fmt64_%0d: got %h/%b required %h/1", i, imm_b, vld_b, eb[i]);
      end
      n_cmp++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL fmt_model_%0d: got %h required %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      tick((k <= 3) ? (32'(k) << 20) | 32'h13 : 32'h0, 0, k <= 3, 0, 0);
      if (k >= 2) begin
        n_cmp++;
        if (imm_b !== 64'(k - 1) || vld_b !== 1'b1) begin
          n_fail++; $display("FAIL stream_%0d: got %h/%b required %h/1", k, imm_b, vld_b, k - 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 8; k++) begin
      tick((32'(k + 4) << 20) | 32'h13, 0, 1, k == 2 || k == 3, 0);
      n_cmp++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL stall_%0d: got %h required %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_flush();
    tick(32'h00500013, 0, 1, 0, 0);
    tick(32'h00600013, 0, 1, 0, 0);
    tick(32'h00700013, 0, 1, 1, 1);
    n_cmp++;
    if (vld_a !== 1'b0 || imm_a !== 32'd0 || vld_b !== 1'b0 || imm_b !== 64'd0) begin
      n_fail++; $display("FAIL flush: got a=%h/%b b=%h/%b required 0/0", imm_a, vld_a, imm_b, vld_b);
    end
    tick(32'h00800013, 0, 1, 0, 0);
    n_cmp++;
    if (vld_b !== 1'b0 || imm_b !== 64'd0 || obs !== expv) begin
      n_fail++; $display("FAIL flush_empty: got %h required %h", obs, expv);
    end
  endtask

  task automatic test_err_count();
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      tick($urandom, 3'd7, 1, 0, 0);
      n_cmp++;
      if (err_a !== 1'b1 || imm_a !== 32'd0 || cnt_b !== 2'((k < 3) ? k + 1 : 3)) begin
        n_fail++; $display("FAIL err_%0d: got err=%b imm=%h cnt=%0d required 1/0/%0d", k, err_a, imm_a, cnt_b, (k < 3) ? k + 1 : 3);
      end
    end
    tick($urandom, 3'd7, 0, 0, 0);
    n_cmp++;
    if (cnt_a !== 8'd5 || err_a !== 1'b0) begin
      n_fail++; $display("FAIL err_invalid: got cnt=%0d err=%b required 5/0", cnt_a, err_a);
    end
    tick($urandom, 3'd7, 1, 0, 1);
    n_cmp++;
    if (cnt_a !== 8'd5 || obs !== expv) begin
      n_fail++; $display("FAIL err_flush: got %h required %h", obs, expv);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick($urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      n_cmp++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL random_%0d: got %h required %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(32'h00100013, 0, 1, 0, 0);
    tick(32'h00200013, 3'd7, 1, 0, 0);
    tick(32'h00300013, 0, 1, 0, 0);
    #2 rst_n = 0;
    model_clear(1);
    #1;
    n_cmp++;
    if (obs !== 110'd0) begin
      n_fail++; $display("FAIL reset_mid: got %h required 0", obs);
    end
    #1 rst_n = 1;
    tick(32'h00900013, 0, 1, 0, 0);
    n_cmp++;
    if (imm_a !== 32'd9 || vld_a !== 1'b1 || vld_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_rel1: got a=%h/%b vb=%b required 9/1/0", imm_a, vld_a, vld_b);
    end
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (imm_b !== 64'd9 || vld_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_rel2: got %h/%b required 9/1", imm_b, vld_b);
    end
  endtask

  initial begin
    model_clear(1);
    #12;
    test_reset();
    test_formats();
    test_back_to_back();
    test_stall();
    test_flush();
    test_err_count();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
